// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters PS2C/PS2D on MCLK, deframes 11-bit frames.
// Optional make/break prefix folding is enabled with `define PS2_MAKE_BREAK_EN.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    output logic       key_break,
    output logic       key_ext
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Odd parity over data plus parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          filt_clk;
    logic          filt_clk_d;
    logic [FW-1:0] filt_cnt;
    logic          fall_evt;
    logic          fall_data;
    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          frame_good;
`ifdef PS2_MAKE_BREAK_EN
    logic          pending_break;
    logic          pending_ext;
`endif

    // Two-flop synchronizers; idle level of both lines is high.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], PS2C};
            d_sync <= {d_sync[0], PS2D};
        end
    end

    // Glitch filter: level follows only after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (c_sync[1] != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= c_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Registered fall strobe with the data line captured alongside it.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            filt_clk_d <= 1'b1;
            fall_evt   <= 1'b0;
            fall_data  <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            fall_evt   <= filt_clk_d & ~filt_clk;
            fall_data  <= d_sync[1];
        end
    end

    // Frame acceptance: stop bit high and odd parity over the byte.
    always_comb begin
        frame_good = 1'b0;
        if (fall_data && odd_parity_ok(shift_reg, par_bit)) begin
            frame_good = 1'b1;
        end else begin
            frame_good = 1'b0;
        end
    end

    // Frame state machine, timeout and output registers.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
`ifdef PS2_MAKE_BREAK_EN
            key_break     <= 1'b0;
            key_ext       <= 1'b0;
            pending_break <= 1'b0;
            pending_ext   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall_evt && !fall_data) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 4'd0;
                        tmo_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (fall_evt) begin
                        tmo_cnt <= '0;
                        if (bit_cnt < 4'd8) begin
                            shift_reg <= {fall_data, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            par_bit <= fall_data;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            state <= ST_IDLE;
                            if (frame_good) begin
`ifdef PS2_MAKE_BREAK_EN
                                // Prefix bytes are folded into the flags of the following code.
                                if (shift_reg == 8'hF0) begin
                                    pending_break <= 1'b1;
                                end else if (shift_reg == 8'hE0) begin
                                    pending_ext <= 1'b1;
                                end else begin
                                    rx_valid      <= 1'b1;
                                    rx_data       <= shift_reg;
                                    key_break     <= pending_break;
                                    key_ext       <= pending_ext;
                                    pending_break <= 1'b0;
                                    pending_ext   <= 1'b0;
                                end
`else
                                rx_valid <= 1'b1;
                                rx_data  <= shift_reg;
`endif
                            end else begin
                                rx_err <= 1'b1;
`ifdef PS2_MAKE_BREAK_EN
                                pending_break <= 1'b0;
                                pending_ext   <= 1'b0;
`endif
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state  <= ST_IDLE;
                        rx_err <= 1'b1;
`ifdef PS2_MAKE_BREAK_EN
                        pending_break <= 1'b0;
                        pending_ext   <= 1'b0;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);

`ifndef PS2_MAKE_BREAK_EN
    assign key_break = 1'b0;
    assign key_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames with a scoreboard of expected rx_valid/rx_err pulses.
// Builds with or without PS2_MAKE_BREAK_EN.
module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 30;

    logic       MCLK = 1'b0;
    logic       reset;
    logic       PS2C;
    logic       PS2D;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;
    logic       key_break;
    logic       key_ext;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
        logic       brk;
        logic       ext;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good;
    int         checks = 0;
    int         errors = 0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .MCLK(MCLK), .reset(reset), .PS2C(PS2C), .PS2D(PS2D),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .busy(busy), .key_break(key_break), .key_ext(key_ext)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every output pulse must match the oldest pending expectation.
    always @(negedge MCLK) begin
        if (!reset && (rx_valid || rx_err)) begin
            chk1("valid_err_exclusive", rx_valid & rx_err, 1'b0);
            if (sb.size() == 0) begin
                chk_int("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk1("pulse_is_err", rx_err, e.err);
                chk8("pulse_rx_data", rx_data, e.data);
                if (rx_valid) begin
                    chk1("pulse_key_break", key_break, e.brk);
                    chk1("pulse_key_ext", key_ext, e.ext);
                end
            end
        end
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic push_good(input logic [7:0] d, input logic brk, input logic ext);
        exp_t e;
        e.err = 1'b0; e.data = d; e.brk = brk; e.ext = ext;
        sb.push_back(e);
        last_good = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b0;
        e.err = 1'b1; e.data = last_good; e.brk = 1'b0; e.ext = 1'b0;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        PS2D = b;
        repeat (HALF) @(negedge MCLK);
        PS2C = 1'b0;
        repeat (HALF) @(negedge MCLK);
        PS2C = 1'b1;
    endtask

    // Sends frame bits [lo, hi); optionally measures rx_valid latency from the stop-bit fall.
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input bit chk_lat);
        int lat;
        for (int i = lo; i < hi; i++) begin
            if (i == 10 && chk_lat) begin
                PS2D = f[i];
                repeat (HALF) @(negedge MCLK);
                PS2C = 1'b0;
                lat = -1;
                for (int k = 0; k < FL + 12; k++) begin
                    @(posedge MCLK);
                    #1;
                    if (rx_valid) begin
                        lat = k;
                        break;
                    end
                end
                chk_int("valid_latency", lat, FL + 3);
                repeat (HALF) @(negedge MCLK);
                PS2C = 1'b1;
            end else begin
                send_bit(f[i]);
            end
        end
        repeat (HALF) @(negedge MCLK);
    endtask

    task automatic glitch();
        @(negedge MCLK);
        PS2C = 1'b0;
        repeat (3) @(negedge MCLK);
        PS2C = 1'b1;
    endtask

    initial begin
        PS2C = 1'b1;
        PS2D = 1'b1;
        reset = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge MCLK);
        reset = 1'b0;
        @(negedge MCLK);
        chk8("reset_rx_data", rx_data, 8'h00);
        chk1("reset_rx_valid", rx_valid, 1'b0);
        chk1("reset_rx_err", rx_err, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_key_break", key_break, 1'b0);
        chk1("reset_key_ext", key_ext, 1'b0);

        // Good frame with latency measurement.
        push_good(8'h1C, 1'b0, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t1_rx_data", rx_data, 8'h1C);
        chk1("t1_busy_idle", busy, 1'b0);

        // Parity error keeps previous byte.
        push_err();
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 0, 11, 1'b0);
        chk8("t2_rx_data_held", rx_data, 8'h1C);

        // Stop-bit error, then recovery.
        push_err();
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 0, 11, 1'b0);
        chk8("t3_rx_data_held", rx_data, 8'h1C);
        push_good(8'h29, 1'b0, 1'b0);
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t3_rx_data", rx_data, 8'h29);

        // Timeout after start plus four data bits.
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 0, 5, 1'b0);
        chk1("t4_busy_partial", busy, 1'b1);
        push_err();
        repeat (TO + 20) @(negedge MCLK);
        chk1("t4_busy_after_timeout", busy, 1'b0);
        chk_int("t4_sb_drained", sb.size(), 0);
        push_good(8'h5A, 1'b0, 1'b0);
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t4_rx_data", rx_data, 8'h5A);

        // Reset mid-frame: no pulses, outputs cleared, next frame clean.
        send_bits(mk_frame(8'h66, 1'b0, 1'b1), 0, 4, 1'b0);
        chk1("t4r_busy_partial", busy, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge MCLK);
        reset = 1'b0;
        last_good = 8'h00;
        @(negedge MCLK);
        chk1("t4r_busy_after_reset", busy, 1'b0);
        chk8("t4r_rx_data_after_reset", rx_data, 8'h00);
        repeat (TO + 20) @(negedge MCLK);
        push_good(8'h33, 1'b0, 1'b0);
        send_bits(mk_frame(8'h33, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t4r_rx_data", rx_data, 8'h33);

        // Short glitches in idle and between bits are filtered out.
        glitch();
        repeat (20) @(negedge MCLK);
        chk1("t5_busy_idle_glitch", busy, 1'b0);
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 0, 3, 1'b0);
        repeat (12) @(negedge MCLK);
        glitch();
        repeat (12) @(negedge MCLK);
        chk1("t5_busy_mid_glitch", busy, 1'b1);
        push_good(8'hA5, 1'b0, 1'b0);
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 3, 11, 1'b1);
        chk8("t5_rx_data", rx_data, 8'hA5);

`ifdef PS2_MAKE_BREAK_EN
        // Prefixes fold into key flags of the next code.
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 11, 1'b0);
        chk8("t6_prefix_no_update", rx_data, 8'hA5);
        push_good(8'h1C, 1'b1, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 11, 1'b1);
        chk1("t6_break_held", key_break, 1'b1);
        chk1("t6_ext_held", key_ext, 1'b0);
        send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 0, 11, 1'b0);
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 11, 1'b0);
        push_good(8'h75, 1'b1, 1'b1);
        send_bits(mk_frame(8'h75, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t6_rx_data", rx_data, 8'h75);
        chk1("t6_ext_set", key_ext, 1'b1);
        // Error clears pending prefix.
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 11, 1'b0);
        push_err();
        send_bits(mk_frame(8'h12, 1'b1, 1'b1), 0, 11, 1'b0);
        push_good(8'h12, 1'b0, 1'b0);
        send_bits(mk_frame(8'h12, 1'b0, 1'b1), 0, 11, 1'b1);
`else
        // Without folding, prefixes are ordinary bytes.
        push_good(8'hF0, 1'b0, 1'b0);
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t6_rx_data_f0", rx_data, 8'hF0);
        push_good(8'hE0, 1'b0, 1'b0);
        send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 0, 11, 1'b1);
        chk8("t6_rx_data_e0", rx_data, 8'hE0);
        chk1("t6_key_break_zero", key_break, 1'b0);
        chk1("t6_key_ext_zero", key_ext, 1'b0);
`endif

        repeat (50) @(negedge MCLK);
        chk_int("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
